uart_tx_cfg: RTL and testbench
==============================

UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLK_DIV, default 44, clk cycles per bit period; legal range 4..65535.
REQ-003 Parameter FIFO_DEPTH, default 4, transmit FIFO entries; power of two, 2..64.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous reset, active-high.
REQ-006 tx_data  input  DATA_W  byte to transmit; sampled when trmt=1.
REQ-007 trmt  input  1  write strobe; one FIFO push per cycle high.
REQ-008 parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 two_stop  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 TX  output  1  serial line; registered output; idles high.
REQ-011 tx_done  output  1  one-cycle pulse at the end of each frame.
REQ-012 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 idle  output  1  FSM in IDLE and FIFO empty.

Function
REQ-014 The FIFO SHALL push tx_data when trmt=1 and full=0; a trmt while full=1 SHALL be discarded with no state change.
REQ-015 full SHALL be evaluated before the same-cycle pop; a push at full is rejected even if a pop occurs that cycle.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START when the FIFO is non-empty: pop the head into the shifter, latch parity_mode and two_stop, drive TX=0.
REQ-018 START -> DATA after CLK_DIV cycles; DATA shifts out LSB first, one bit per CLK_DIV cycles, for DATA_W bits.
REQ-019 DATA -> PARITY after bit DATA_W-1 if the latched mode is even/odd, else -> STOP.
REQ-020 Parity bit: even = XOR of data bits; odd = inverted XOR; it lasts CLK_DIV cycles.
REQ-021 STOP drives TX=1 for CLK_DIV cycles (one stop) or 2*CLK_DIV cycles (two stop).
REQ-022 At the end of STOP, tx_done SHALL pulse for exactly 1 cycle.
REQ-023 At the end of STOP, the FSM SHALL go to START directly (pop) if the FIFO is non-empty, with no idle gap; otherwise it SHALL go to IDLE.
REQ-024 Every bit period SHALL be exactly CLK_DIV cycles; the baud counter restarts at each bit boundary.
REQ-025 From IDLE with an empty FIFO, TX SHALL fall exactly 2 cycles after the edge sampling trmt=1.
REQ-026 Changes to parity_mode or two_stop mid-frame SHALL NOT affect the frame in progress.
REQ-027 Frame length in bits SHALL be 1 + DATA_W + (parity?1:0) + (two_stop?2:1).

Reset
REQ-028 rst=1 SHALL immediately force TX=1, tx_done=0, full=0, idle=1, FSM=IDLE, FIFO empty, and all counters to 0, regardless of clk.
REQ-029 A reset mid-frame SHALL abort the frame and discard all queued entries; no tx_done is issued for the aborted frame.
REQ-030 After rst deasserts, the first rising edge SHALL accept trmt normally.

Verification (DATA_W=8, CLK_DIV=44, FIFO_DEPTH=4)
REQ-031 Push 0xA5, parity 00, two_stop 0 -> TX = 0,1,0,1,0,0,1,0,1,1, each 44 cycles; tx_done pulses once, 440 cycles after TX falls; idle=1 next cycle.
REQ-032 Push 0x07 with parity 01 -> parity bit 1; repeat with parity 10 -> parity bit 0; frame = 484 cycles.
REQ-033 two_stop=1, push 0x00 -> TX high for 88 cycles after the data bits; frame = 484 cycles.
REQ-034 Push 6 bytes on consecutive cycles from idle -> first byte is popped, 4 are queued, full=1, sixth byte is dropped; 5 contiguous frames with no high gap between a stop bit and the next start bit; 5 tx_done pulses.
REQ-035 Assert rst during bit 3 of a frame with 2 entries queued -> TX=1 at once, idle=1; no further frames or tx_done after release.
REQ-036 Toggle parity_mode from 00 to 01 during DATA -> the current frame has no parity bit; the next frame carries parity.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// rtl/uart_tx_cfg.sv - configurable UART transmitter with transmit FIFO
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   tx_data      word to queue, sampled while trmt=1
//   trmt         write strobe, one FIFO push per cycle when not full
//   parity_mode  00 none, 01 even, 10 odd, 11 none (latched per frame)
//   two_stop     0 one stop bit, 1 two stop bits (latched per frame)
//   TX           registered serial line, idles high
//   tx_done      one-cycle pulse at the end of each frame on the line
//   full         FIFO holds FIFO_DEPTH entries
//   idle         FSM in IDLE and FIFO empty
`timescale 1ns/1ps
module uart_tx_cfg #(
    parameter int DATA_W     = 8,
    parameter int CLK_DIV    = 44,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              trmt,
    input  logic [1:0]        parity_mode,
    input  logic              two_stop,
    output logic              TX,
    output logic              tx_done,
    output logic              full,
    output logic              idle
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] LAST_CNT  = 16'(CLK_DIV - 1);
    localparam logic [3:0]  LAST_DATA = 4'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    // FIFO
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              empty, push, pop;
    logic [DATA_W-1:0] head;

    // FSM and datapath
    state_t            state, next_state;
    logic [15:0]       cnt;
    logic [3:0]        bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_bit, par_en, stop2;
    logic              bit_end, done_c, tx_bit, tx_done_d;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    // full is judged before any same-cycle pop, so a push at full is lost
    assign push  = trmt & ~full;
    assign head  = mem[rd_ptr];
    assign idle  = (state == IDLE) & empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    assign bit_end = (cnt == LAST_CNT);

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                if (bit_end)
                    next_state = DATA;
            end
            DATA: begin
                if (bit_end && bit_idx == LAST_DATA)
                    next_state = par_en ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end)
                    next_state = STOP;
            end
            STOP: begin
                // bit_idx counts completed stop bits within this state
                if (bit_end && bit_idx == {3'b000, stop2}) begin
                    done_c = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        tx_bit = 1'b1;
        case (state)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shreg[0];
            PARITY:  tx_bit = par_bit;
            default: tx_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            par_en    <= 1'b0;
            stop2     <= 1'b0;
            TX        <= 1'b1;
            tx_done_d <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            // baud counter restarts on every bit boundary and state change
            if (next_state != state || bit_end || state == IDLE)
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;

            if (next_state != state)
                bit_idx <= '0;
            else if (bit_end)
                bit_idx <= bit_idx + 4'd1;

            if (pop) begin
                shreg   <= head;
                par_en  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit <= (parity_mode == 2'b10) ? ~(^head) : (^head);
                stop2   <= two_stop;
            end else if (state == DATA && bit_end) begin
                shreg <= shreg >> 1;
            end

            // TX lags the FSM by one cycle; tx_done is delayed to match
            // the end of the stop bit as seen on the line
            TX        <= tx_bit;
            tx_done_d <= done_c;
            tx_done   <= tx_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb/tb_uart_tx_cfg.sv - directed self-checking bench for uart_tx_cfg
`timescale 1ns/1ps
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       trmt = 1'b0;
    logic [1:0] parity_mode = 2'b00;
    logic       two_stop = 1'b0;
    logic       TX, tx_done, full, idle;

    logic [1:0] par_switch = 2'b00;
    int         n_checks = 0;
    int         n_err = 0;

    uart_tx_cfg #(.DATA_W(8), .CLK_DIV(44), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .trmt(trmt),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .TX(TX), .tx_done(tx_done), .full(full), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        tx_data = d;
        trmt    = 1'b1;
        @(negedge clk);
        trmt    = 1'b0;
    endtask

    task automatic set_par(input logic [1:0] m);
        parity_mode = m;
        par_switch  = m;
    endtask

    // j counts negedges from the first negedge with the start bit on TX.
    // Bits are sampled mid-period; tx_done must appear at j = 44*nbits.
    task automatic expect_frame(input string tag, input logic [15:0] exp_bits,
                                input int nbits, input int exp_lat, input int j0);
        logic [15:0] got;
        int lat, done_pos, pulses;
        got = '0; lat = 0; done_pos = -1; pulses = 0;
        if (exp_lat >= 0) begin
            while (TX !== 1'b0 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check({tag, "_lat"}, lat, exp_lat);
        end
        check({tag, "_start"}, TX, 1'b0);
        for (int j = j0 + 1; j <= 44 * nbits; j++) begin
            @(negedge clk);
            if (j == 100)
                parity_mode = par_switch;
            if (j >= 22 && (j - 22) % 44 == 0 && (j - 22) / 44 < nbits)
                got[(j - 22) / 44] = TX;
            if (tx_done === 1'b1) begin
                pulses++;
                if (done_pos < 0)
                    done_pos = j;
            end
        end
        check({tag, "_bits"}, got, exp_bits);
        check({tag, "_done_pos"}, done_pos, 44 * nbits);
        check({tag, "_pulses"}, pulses, 1);
    endtask

    initial begin
        int bad;
        logic [7:0] d [6];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
        d[3] = 8'h44; d[4] = 8'h55; d[5] = 8'h66;

        repeat (3) @(negedge clk);
        check("rst_tx", TX, 1'b1);
        check("rst_done", tx_done, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_idle", idle, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5, no parity, one stop
        send(8'hA5);
        expect_frame("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 2, 0);
        @(negedge clk);
        check("a5_idle", idle, 1'b1);
        check("a5_done_low", tx_done, 1'b0);

        // parity even / odd on 0x07 (three ones)
        set_par(2'b01);
        send(8'h07);
        expect_frame("even", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 2, 0);
        set_par(2'b10);
        send(8'h07);
        expect_frame("odd", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 2, 0);

        // mode 11 behaves as no parity
        set_par(2'b11);
        send(8'h5A);
        expect_frame("p11", {6'b0, 1'b1, 8'h5A, 1'b0}, 10, 2, 0);

        // two stop bits
        set_par(2'b00);
        two_stop = 1'b1;
        send(8'h00);
        expect_frame("stop2", {5'b0, 2'b11, 8'h00, 1'b0}, 11, 2, 0);
        two_stop = 1'b0;
        repeat (3) @(negedge clk);

        // six pushes back to back: one popped, four queued, sixth dropped
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5)
                check("burst_full_before", full, 1'b1);
            tx_data = d[i];
            trmt    = 1'b1;
        end
        @(negedge clk);
        trmt = 1'b0;
        check("burst_full_after", full, 1'b1);
        expect_frame("burst0", {6'b0, 1'b1, d[0], 1'b0}, 10, -1, 3);
        for (int i = 1; i < 5; i++)
            expect_frame($sformatf("burst%0d", i), {6'b0, 1'b1, d[i], 1'b0}, 10, -1, 0);
        @(negedge clk);
        check("burst_idle", idle, 1'b1);
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || tx_done !== 1'b0)
                bad++;
        end
        check("burst_no_sixth", bad, 0);

        // parity change mid-frame only affects the following frame
        set_par(2'b00);
        par_switch = 2'b01;
        send(8'h07);
        send(8'h07);
        expect_frame("tog0", {6'b0, 1'b1, 8'h07, 1'b0}, 10, 0, 0);
        expect_frame("tog1", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 0);
        set_par(2'b00);
        repeat (3) @(negedge clk);

        // reset mid-frame with two entries queued
        send(8'hF0);
        send(8'h0F);
        send(8'hAA);
        bad = 0;
        while (TX !== 1'b0 && bad < 20) begin
            @(negedge clk);
            bad++;
        end
        repeat (44 * 3 + 22) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx", TX, 1'b1);
        check("mid_rst_idle", idle, 1'b1);
        check("mid_rst_full", full, 1'b0);
        check("mid_rst_done", tx_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (TX !== 1'b1 || tx_done !== 1'b0 || idle !== 1'b1)
                bad++;
        end
        check("mid_rst_quiet", bad, 0);

        // first edge after reset release accepts trmt
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        tx_data = 8'h3C;
        trmt    = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
        expect_frame("post_rst", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 2, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
